reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 131 +++++++++++++
 tb/tb_reg_file.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file with rename tracking for an out-of-order core.
// Each register carries a busy flag and the ROB tag of its pending producer;
// source operands are resolved combinationally from the register file, the
// committing instruction, or the ROB itself.
module reg_file #(
  parameter int ROB_BIT = 4,
  parameter int REG_BIT = 5
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_up,
  input  logic               issue_valid,
  input  logic [REG_BIT-1:0] issue_reg_id,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic               commit_valid,
  input  logic [REG_BIT-1:0] commit_rd_reg_id,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [31:0]        commit_value,
  input  logic [REG_BIT-1:0] rs1_id,
  input  logic [REG_BIT-1:0] rs2_id,
  output logic [31:0]        rs1_value,
  output logic [31:0]        rs2_value,
  output logic               rs1_dep_valid,
  output logic               rs2_dep_valid,
  output logic [ROB_BIT-1:0] rs1_dep,
  output logic [ROB_BIT-1:0] rs2_dep,
  output logic [ROB_BIT-1:0] get_rob_entry1,
  output logic [ROB_BIT-1:0] get_rob_entry2,
  input  logic               ready1,
  input  logic               ready2,
  input  logic [31:0]        value1,
  input  logic [31:0]        value2
);

  localparam int unsigned NREG = 1 << REG_BIT;

  logic [31:0]        regs [NREG];
  logic               busy [NREG];
  logic [ROB_BIT-1:0] tag  [NREG];

  // A same-cycle issue to the committing register keeps it busy under the new tag.
  logic issue_live;
  logic commit_retires;

  // Decode which of this cycle's rename/retire events actually change busy state.
  always_comb begin
    issue_live     = issue_valid && !clear_up && (issue_reg_id != '0);
    commit_retires = commit_valid && (commit_rd_reg_id != '0)
                     && busy[commit_rd_reg_id]
                     && (tag[commit_rd_reg_id] == commit_rob_entry)
                     && !(issue_live && (issue_reg_id == commit_rd_reg_id));
  end

  // State update: reset dominates, rdy_in low freezes, flush clears rename state
  // but the committed value is still written back.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        busy[i] <= 1'b0;
        tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (commit_valid && (commit_rd_reg_id != '0)) begin
        regs[commit_rd_reg_id] <= commit_value;
      end
      if (clear_up) begin
        for (int unsigned i = 0; i < NREG; i++) begin
          busy[i] <= 1'b0;
          tag[i]  <= '0;
        end
      end else begin
        if (commit_retires) begin
          busy[commit_rd_reg_id] <= 1'b0;
        end
        if (issue_live) begin
          busy[issue_reg_id] <= 1'b1;
          tag[issue_reg_id]  <= issue_rob_entry;
        end
      end
    end
  end

  // ROB lookups always follow the current tag of each source register.
  always_comb begin
    get_rob_entry1 = tag[rs1_id];
    get_rob_entry2 = tag[rs2_id];
  end

  // Resolve source operand 1: x0, idle register, committing bypass, ROB value, or wait.
  always_comb begin
    rs1_value     = '0;
    rs1_dep_valid = 1'b0;
    rs1_dep       = '0;
    if (rs1_id == '0) begin
      rs1_value = '0;
    end else if (!busy[rs1_id]) begin
      rs1_value = regs[rs1_id];
    end else if (commit_valid && (commit_rd_reg_id == rs1_id)
                 && (commit_rob_entry == tag[rs1_id])) begin
      rs1_value = commit_value;
    end else if (ready1) begin
      rs1_value = value1;
    end else begin
      rs1_dep_valid = 1'b1;
      rs1_dep       = tag[rs1_id];
    end
  end

  // Resolve source operand 2 with the same priority as operand 1.
  always_comb begin
    rs2_value     = '0;
    rs2_dep_valid = 1'b0;
    rs2_dep       = '0;
    if (rs2_id == '0) begin
      rs2_value = '0;
    end else if (!busy[rs2_id]) begin
      rs2_value = regs[rs2_id];
    end else if (commit_valid && (commit_rd_reg_id == rs2_id)
                 && (commit_rob_entry == tag[rs2_id])) begin
      rs2_value = commit_value;
    end else if (ready2) begin
      rs2_value = value2;
    end else begin
      rs2_dep_valid = 1'b1;
      rs2_dep       = tag[rs2_id];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with literal expectations
// plus a per-cycle comparison against a behavioural register/rename model.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_up;
  logic        issue_valid;
  logic [4:0]  issue_reg_id;
  logic [3:0]  issue_rob_entry;
  logic        commit_valid;
  logic [4:0]  commit_rd_reg_id;
  logic [3:0]  commit_rob_entry;
  logic [31:0] commit_value;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_value, rs2_value;
  logic        rs1_dep_valid, rs2_dep_valid;
  logic [3:0]  rs1_dep, rs2_dep;
  logic [3:0]  get_rob_entry1, get_rob_entry2;
  logic        ready1, ready2;
  logic [31:0] value1, value2;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Behavioural view of architectural state.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  reg_file #(.ROB_BIT(4), .REG_BIT(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_up(clear_up),
    .issue_valid(issue_valid), .issue_reg_id(issue_reg_id), .issue_rob_entry(issue_rob_entry),
    .commit_valid(commit_valid), .commit_rd_reg_id(commit_rd_reg_id),
    .commit_rob_entry(commit_rob_entry), .commit_value(commit_value),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_dep_valid(rs1_dep_valid), .rs2_dep_valid(rs2_dep_valid),
    .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
    .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
    .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected operand from the model: x0, idle reg, commit bypass, ROB value, else wait.
  function automatic void exp_op(input int id, input logic rdy, input logic [31:0] v,
                                 output logic [31:0] val, output logic dv, output logic [3:0] dep);
    val = '0; dv = 1'b0; dep = '0;
    if (id == 0) val = '0;
    else if (!m_busy[id]) val = m_regs[id];
    else if (commit_valid && int'(commit_rd_reg_id) == id && commit_rob_entry == m_tag[id])
      val = commit_value;
    else if (rdy) val = v;
    else begin dv = 1'b1; dep = m_tag[id]; end
  endfunction

  // Model update on each rising edge from the inputs presented during that cycle.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; m_tag[i] = '0; end
    end else if (rdy_in) begin
      int cr, ir;
      cr = int'(commit_rd_reg_id);
      ir = int'(issue_reg_id);
      if (commit_valid && cr != 0) m_regs[cr] = commit_value;
      if (clear_up) begin
        for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = '0; end
      end else begin
        if (commit_valid && cr != 0 && m_busy[cr] && m_tag[cr] == commit_rob_entry
            && !(issue_valid && ir == cr))
          m_busy[cr] = 0;
        if (issue_valid && ir != 0) begin m_busy[ir] = 1; m_tag[ir] = issue_rob_entry; end
      end
    end
  end

  // Per-cycle comparison of every combinational output, away from the active edge.
  always @(negedge clk_in) begin
    if (check_en) begin
      logic [31:0] v; logic dv; logic [3:0] dp;
      exp_op(int'(rs1_id), ready1, value1, v, dv, dp);
      chk("rs1_value", rs1_value, v);
      chk("rs1_dep_valid", {31'b0, rs1_dep_valid}, {31'b0, dv});
      chk("rs1_dep", {28'b0, rs1_dep}, {28'b0, dp});
      exp_op(int'(rs2_id), ready2, value2, v, dv, dp);
      chk("rs2_value", rs2_value, v);
      chk("rs2_dep_valid", {31'b0, rs2_dep_valid}, {31'b0, dv});
      chk("rs2_dep", {28'b0, rs2_dep}, {28'b0, dp});
      chk("get_rob_entry1", {28'b0, get_rob_entry1}, {28'b0, m_tag[rs1_id]});
      chk("get_rob_entry2", {28'b0, get_rob_entry2}, {28'b0, m_tag[rs2_id]});
    end
  end

  task automatic idle();
    rst_in = 1'b1; rdy_in = 1'b1; clear_up = 1'b0;
    issue_valid = 1'b0; issue_reg_id = '0; issue_rob_entry = '0;
    commit_valid = 1'b0; commit_rd_reg_id = '0; commit_rob_entry = '0; commit_value = '0;
    ready1 = 1'b0; ready2 = 1'b0; value1 = '0; value2 = '0;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic [3:0] t);
    issue_valid = 1'b1; issue_reg_id = r; issue_rob_entry = t;
  endtask

  task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    commit_valid = 1'b1; commit_rd_reg_id = r; commit_rob_entry = t; commit_value = v;
  endtask

  // Literal check of operand 1 after combinational settling.
  task automatic lit1(input string name, input logic [31:0] v, input logic dv, input logic [3:0] dp);
    #1;
    chk({name, "_val"}, rs1_value, v);
    chk({name, "_dv"}, {31'b0, rs1_dep_valid}, {31'b0, dv});
    chk({name, "_dep"}, {28'b0, rs1_dep}, {28'b0, dp});
  endtask

  initial begin
    idle();
    rs1_id = '0; rs2_id = '0;
    rst_in = 1'b0;
    tick();
    check_en = 1'b1;
    tick();
    rst_in = 1'b1;

    // Reset state.
    lit1("reset_rs1", 32'h0, 1'b0, 4'h0);
    chk("reset_get1", {28'b0, get_rob_entry1}, 32'h0);
    chk("reset_rs2", rs2_value, 32'h0);

    // Commit to an idle register; visible next cycle.
    commit(5'd5, 4'd3, 32'h1234); tick(); idle();
    rs1_id = 5'd5;
    lit1("commit_x5", 32'h1234, 1'b0, 4'h0);
    chk("model_x5", m_regs[5], 32'h1234);

    // Rename then wait on / read from the ROB.
    issue(5'd7, 4'd2); tick(); idle();
    rs1_id = 5'd7;
    lit1("dep_x7", 32'h0, 1'b1, 4'd2);
    chk("get1_x7", {28'b0, get_rob_entry1}, 32'd2);
    ready1 = 1'b1; value1 = 32'hAA;
    lit1("rob_x7", 32'hAA, 1'b0, 4'h0);
    tick();

    // Commit and re-issue of the same register in one cycle: issue wins busy.
    idle(); rs1_id = 5'd7;
    commit(5'd7, 4'd2, 32'd9); issue(5'd7, 4'd5);
    lit1("bypass_x7", 32'd9, 1'b0, 4'h0);
    tick(); idle();
    lit1("reissue_x7", 32'h0, 1'b1, 4'd5);
    chk("model_tag7", {28'b0, m_tag[7]}, 32'd5);
    clear_up = 1'b1; tick(); idle();
    lit1("flushed_x7", 32'd9, 1'b0, 4'h0);

    // Stale commit must not clear a newer rename.
    issue(5'd3, 4'd1); tick(); issue(5'd3, 4'd4); tick(); idle();
    commit(5'd3, 4'd1, 32'h11); rs1_id = 5'd3;
    lit1("stale_commit_x3", 32'h0, 1'b1, 4'd4);
    tick(); idle(); rs1_id = 5'd3;
    lit1("still_busy_x3", 32'h0, 1'b1, 4'd4);
    clear_up = 1'b1; tick(); idle();
    lit1("regs_x3", 32'h11, 1'b0, 4'h0);

    // Flush drops a same-cycle issue.
    issue(5'd8, 4'd1); tick(); issue(5'd9, 4'd2); tick(); idle();
    clear_up = 1'b1; issue(5'd10, 4'd6); tick(); idle();
    rs1_id = 5'd8; rs2_id = 5'd10;
    lit1("flush_x8", 32'h0, 1'b0, 4'h0);
    chk("flush_x10_dv", {31'b0, rs2_dep_valid}, 32'h0);
    chk("flush_x10_get", {28'b0, get_rob_entry2}, 32'h0);
    rs1_id = 5'd9;
    lit1("flush_x9", 32'h0, 1'b0, 4'h0);

    // Stall freezes everything.
    rdy_in = 1'b0; issue(5'd8, 4'd7); commit(5'd8, 4'd7, 32'h55); tick();
    rdy_in = 1'b0; clear_up = 1'b1; commit(5'd5, 4'd0, 32'h77); tick(); idle();
    rs1_id = 5'd8; rs2_id = 5'd5;
    lit1("stall_x8", 32'h0, 1'b0, 4'h0);
    chk("stall_x5", rs2_value, 32'h1234);

    // x0 ignores writes and renames.
    commit(5'd0, 4'd3, 32'hFFFF); issue(5'd0, 4'd3); tick(); idle();
    rs1_id = 5'd0;
    lit1("x0", 32'h0, 1'b0, 4'h0);
    chk("x0_get", {28'b0, get_rob_entry1}, 32'h0);

    // Same-cycle issue does not disturb the operand read.
    rs1_id = 5'd5; issue(5'd5, 4'd1);
    lit1("issue_same_cycle", 32'h1234, 1'b0, 4'h0);
    tick(); idle();
    // Wrong-tag commit does not bypass; matching tag does.
    rs1_id = 5'd5; commit(5'd5, 4'd8, 32'hBEEF);
    lit1("wrong_tag", 32'h0, 1'b1, 4'd1);
    commit(5'd5, 4'd1, 32'hBEEF);
    lit1("right_tag", 32'hBEEF, 1'b0, 4'h0);
    tick(); idle();

    // Reset overrides concurrent activity.
    issue(5'd4, 4'd5); tick(); idle();
    rst_in = 1'b0; issue(5'd4, 4'd9); commit(5'd4, 4'd5, 32'h42); clear_up = 1'b1; tick(); idle();
    rs1_id = 5'd4; rs2_id = 5'd5;
    lit1("reset_mid", 32'h0, 1'b0, 4'h0);
    chk("reset_mid_x5", rs2_value, 32'h0);

    // Mixed traffic on a few registers, including tag wrap and collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy_in = ($urandom_range(0, 7) != 0);
      clear_up = ($urandom_range(0, 19) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_reg_id = 5'($urandom_range(0, 5));
      issue_rob_entry = 4'($urandom);
      commit_valid = $urandom_range(0, 1) == 1;
      commit_rd_reg_id = 5'($urandom_range(0, 5));
      commit_rob_entry = (n % 2 == 0) ? m_tag[commit_rd_reg_id] : 4'($urandom);
      commit_value = $urandom;
      rs1_id = 5'($urandom_range(0, 5));
      rs2_id = 5'($urandom_range(0, 5));
      ready1 = $urandom_range(0, 1) == 1; value1 = $urandom;
      ready2 = $urandom_range(0, 1) == 1; value2 = $urandom;
      tick();
    end

    idle();
    tick();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
